// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates, line/frame periods and a lock flag from the
// hsync/vsync pair of a same-clock VGA timing source.
module vga_sync_decoder #(
    parameter int   CX         = 11,
    parameter int   CY         = 10,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0,
    parameter int   LOCK_LINES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hsync_in,
    input  logic          vsync_in,
    output logic [CX-1:0] h_pos,
    output logic [CY-1:0] v_pos,
    output logic [CX-1:0] line_len,
    output logic [CY-1:0] frame_lines,
    output logic          line_start,
    output logic          frame_start,
    output logic          locked
);

    // state  | meaning
    // SEARCH | waiting for LOCK_LINES consecutive equal-length lines
    // HLOCK  | line length stable, waiting for two equal frame heights
    // LOCKED | full timing stable, locked asserted
    typedef enum logic [1:0] {SEARCH, HLOCK, LOCKED} state_t;

    localparam logic [CX-1:0] H_MAX  = '1;
    localparam logic [CY-1:0] V_MAX  = '1;
    localparam logic [CX-1:0] H_ONE  = CX'(1);
    localparam logic [CY-1:0] V_ONE  = CY'(1);
    localparam logic [3:0]    LOCK_N = 4'(LOCK_LINES);

    state_t state, state_nxt;
    logic fref, fref_nxt;
    logic hs, vs, hs_q1, hs_q2, vs_q1, vs_q2;
    logic h_edge, v_edge, vpend, frame_evt;
    logic line_match, frame_match;
    logic [CX-1:0] h_inc;
    logic [CY-1:0] v_inc;
    logic [3:0] mcnt, mcnt_nxt;

    // Internally both syncs are active-high regardless of source polarity.
    assign hs = hsync_in ^ ~HS_POL;
    assign vs = vsync_in ^ ~VS_POL;

    assign h_edge      = hs_q1 & ~hs_q2;
    assign v_edge      = vs_q1 & ~vs_q2;
    assign frame_evt   = h_edge & (vpend | v_edge);
    assign h_inc       = h_pos + H_ONE;
    assign v_inc       = v_pos + V_ONE;
    assign line_match  = (h_inc == line_len);
    assign frame_match = (v_inc == frame_lines);

    always_comb begin
        mcnt_nxt = 4'd0;
        if (line_match)
            mcnt_nxt = (mcnt == LOCK_N) ? mcnt : mcnt + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEARCH;
            fref  <= 1'b0;
        end else begin
            state <= state_nxt;
            fref  <= fref_nxt;
        end
    end

    // fref marks that a reference frame height was captured inside HLOCK.
    always_comb begin
        state_nxt = state;
        fref_nxt  = fref;
        case (state)
            SEARCH: begin
                fref_nxt = 1'b0;
                if (h_edge && mcnt_nxt == LOCK_N)
                    state_nxt = HLOCK;
            end
            HLOCK: begin
                if (h_edge && !line_match) begin
                    state_nxt = SEARCH;
                    fref_nxt  = 1'b0;
                end else if (frame_evt) begin
                    fref_nxt = 1'b1;
                    if (fref && frame_match && v_inc != '0)
                        state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                fref_nxt = 1'b0;
                if ((h_edge && !line_match) || (frame_evt && !frame_match) || h_pos == H_MAX)
                    state_nxt = SEARCH;
            end
            default: begin
                state_nxt = SEARCH;
                fref_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q1       <= 1'b0;
            hs_q2       <= 1'b0;
            vs_q1       <= 1'b0;
            vs_q2       <= 1'b0;
            h_pos       <= '0;
            v_pos       <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vpend       <= 1'b0;
            mcnt        <= 4'd0;
            locked      <= 1'b0;
        end else begin
            hs_q1       <= hs;
            hs_q2       <= hs_q1;
            vs_q1       <= vs;
            vs_q2       <= vs_q1;
            line_start  <= h_edge;
            frame_start <= frame_evt;
            locked      <= (state_nxt == LOCKED);

            if (h_edge) begin
                h_pos    <= '0;
                line_len <= h_inc;
                mcnt     <= mcnt_nxt;
            end else if (h_pos != H_MAX) begin
                h_pos <= h_inc;
            end

            // A vsync edge is held until the next line start consumes it.
            if (frame_evt) begin
                v_pos       <= '0;
                frame_lines <= v_inc;
                vpend       <= 1'b0;
            end else begin
                if (h_edge && v_pos != V_MAX)
                    v_pos <= v_inc;
                if (v_edge)
                    vpend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: an active-low and an active-high instance driven
// with mirrored sync streams, both checked every cycle against one model.
module tb_vga_sync_decoder;

    localparam int CX   = 8;
    localparam int CY   = 6;
    localparam int LOCK = 4;
    localparam int HMOD = 1 << CX;
    localparam int HMAX = HMOD - 1;
    localparam int VMOD = 1 << CY;
    localparam int VMAX = VMOD - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hsync_a = 1'b1, vsync_a = 1'b1;
    logic hsync_b = 1'b0, vsync_b = 1'b0;

    logic [CX-1:0] a_h_pos, a_line_len, b_h_pos, b_line_len;
    logic [CY-1:0] a_v_pos, a_frame_lines, b_v_pos, b_frame_lines;
    logic a_ls, a_fs, a_lk, b_ls, b_fs, b_lk;

    int n_tests = 0;
    int n_fail  = 0;
    int vs_left = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    vga_sync_decoder #(.CX(CX), .CY(CY), .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_LINES(LOCK)) u_a (
        .clk(clk), .rst(rst), .hsync_in(hsync_a), .vsync_in(vsync_a),
        .h_pos(a_h_pos), .v_pos(a_v_pos), .line_len(a_line_len), .frame_lines(a_frame_lines),
        .line_start(a_ls), .frame_start(a_fs), .locked(a_lk));

    vga_sync_decoder #(.CX(CX), .CY(CY), .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_LINES(LOCK)) u_b (
        .clk(clk), .rst(rst), .hsync_in(hsync_b), .vsync_in(vsync_b),
        .h_pos(b_h_pos), .v_pos(b_v_pos), .line_len(b_line_len), .frame_lines(b_frame_lines),
        .line_start(b_ls), .frame_start(b_fs), .locked(b_lk));

    // Reference model: sync histories are the sampled active levels of the
    // source; phase 0/1/2 = searching / line-locked / fully locked.
    bit m_h1, m_h2, m_v1, m_v2, m_vp;
    int e_hpos, e_vpos, e_ll, e_fl, e_ls, e_fs, e_lk;
    int run, phase, fcount;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_h1 <= 0; m_h2 <= 0; m_v1 <= 0; m_v2 <= 0; m_vp <= 0;
            e_hpos <= 0; e_vpos <= 0; e_ll <= 0; e_fl <= 0;
            e_ls <= 0; e_fs <= 0; e_lk <= 0;
            run <= 0; phase <= 0; fcount <= 0;
        end else begin
            bit he, ve, fs, lm, fm;
            int nh, nv, run_n, ph_n, fc_n;
            he = m_h1 && !m_h2;
            ve = m_v1 && !m_v2;
            fs = he && (m_vp || ve);
            nh = (e_hpos + 1) % HMOD;
            nv = (e_vpos + 1) % VMOD;
            lm = (nh == e_ll);
            fm = (nv == e_fl);
            run_n = he ? (lm ? run + 1 : 0) : run;
            ph_n = phase;
            fc_n = fcount;
            if (phase == 0) begin
                if (he && run_n >= LOCK) begin ph_n = 1; fc_n = 0; end
            end else if (phase == 1) begin
                if (he && !lm) ph_n = 0;
                else if (fs) begin
                    fc_n = fcount + 1;
                    if (fc_n >= 2 && fm && nv != 0) ph_n = 2;
                end
            end else begin
                if ((he && !lm) || (fs && !fm) || e_hpos == HMAX) ph_n = 0;
            end
            run <= run_n; phase <= ph_n; fcount <= fc_n;
            e_lk <= (ph_n == 2);
            e_ls <= he;
            e_fs <= fs;
            if (he) begin e_ll <= nh; e_hpos <= 0; end
            else e_hpos <= (e_hpos < HMAX) ? e_hpos + 1 : HMAX;
            if (fs) begin e_fl <= nv; e_vpos <= 0; m_vp <= 0; end
            else begin
                if (he && e_vpos < VMAX) e_vpos <= e_vpos + 1;
                if (ve) m_vp <= 1;
            end
            m_h1 <= !hsync_a; m_h2 <= m_h1;
            m_v1 <= !vsync_a; m_v2 <= m_v1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("a.h_pos", a_h_pos, e_hpos);
            chk("a.v_pos", a_v_pos, e_vpos);
            chk("a.line_len", a_line_len, e_ll);
            chk("a.frame_lines", a_frame_lines, e_fl);
            chk("a.line_start", a_ls, e_ls);
            chk("a.frame_start", a_fs, e_fs);
            chk("a.locked", a_lk, e_lk);
            chk("b.h_pos", b_h_pos, e_hpos);
            chk("b.v_pos", b_v_pos, e_vpos);
            chk("b.line_len", b_line_len, e_ll);
            chk("b.frame_lines", b_frame_lines, e_fl);
            chk("b.line_start", b_ls, e_ls);
            chk("b.frame_start", b_fs, e_fs);
            chk("b.locked", b_lk, e_lk);
        end
    end

    task automatic cyc(input bit h, input bit v);
        @(posedge clk);
        #1;
        hsync_a = !h; vsync_a = !v;
        hsync_b = h;  vsync_b = v;
    endtask

    task automatic line(input int len, input int hw, input int vstart, input int vlen,
                        input int from, input int to);
        for (int c = from; c < to; c++) begin
            if (c == vstart) vs_left = vlen;
            cyc(c < hw, vs_left > 0);
            if (vs_left > 0) vs_left--;
        end
    endtask

    task automatic frame(input int nl, input int len, input int valign);
        for (int l = 0; l < nl; l++)
            line(len, 1, (l == 0) ? valign : -1, len, 0, len);
    endtask

    task automatic pin_zero(input string tag);
        chk({tag, ".h_pos"}, a_h_pos, 0);
        chk({tag, ".v_pos"}, a_v_pos, 0);
        chk({tag, ".line_len"}, a_line_len, 0);
        chk({tag, ".frame_lines"}, a_frame_lines, 0);
        chk({tag, ".line_start"}, a_ls, 0);
        chk({tag, ".frame_start"}, a_fs, 0);
        chk({tag, ".locked"}, a_lk, 0);
        chk({tag, ".b_locked"}, b_lk, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        pin_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // nominal: 10-clock lines, 6-line frames, vsync aligned with hsync
        for (int f = 0; f < 8; f++) frame(6, 10, 0);
        @(negedge clk);
        chk("nominal.line_len", a_line_len, 10);
        chk("nominal.frame_lines", a_frame_lines, 6);
        chk("nominal.locked", a_lk, 1);
        chk("nominal.b_locked", b_lk, 1);

        // one line shortened to 8 clocks
        line(10, 1, 0, 10, 0, 10);
        line(10, 1, -1, 10, 0, 10);
        line(8, 1, -1, 10, 0, 8);
        line(10, 1, -1, 10, 0, 3);
        @(negedge clk);
        chk("short.line_len", a_line_len, 8);
        chk("short.locked", a_lk, 0);
        line(10, 1, -1, 10, 3, 10);
        line(10, 1, -1, 10, 0, 10);
        line(10, 1, -1, 10, 0, 10);
        for (int f = 0; f < 4; f++) frame(6, 10, 0);
        @(negedge clk);
        chk("relock.locked", a_lk, 1);

        // randomized timing disturbances
        for (int f = 0; f < 40; f++) begin
            int nl, vst, vl;
            nl  = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 8) : 6;
            vst = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, 5);
            vl  = $urandom_range(1, 25);
            for (int l = 0; l < nl; l++) begin
                int len;
                len = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 14) : 10;
                line(len, $urandom_range(1, 3), (l == 0) ? vst : -1, vl, 0, len);
            end
        end

        // hsync lost: h_pos must saturate, lock must drop
        for (int f = 0; f < 5; f++) frame(6, 10, 0);
        for (int i = 0; i < 300; i++) cyc(1'b0, 1'b0);
        @(negedge clk);
        chk("hold.h_pos", a_h_pos, HMAX);
        chk("hold.locked", a_lk, 0);

        // aligned then mid-line vsync: both keep 6-line frames
        for (int f = 0; f < 6; f++) frame(6, 10, 0);
        @(negedge clk);
        chk("aligned.frame_lines", a_frame_lines, 6);
        chk("aligned.locked", a_lk, 1);
        for (int f = 0; f < 6; f++) frame(6, 10, 5);
        @(negedge clk);
        chk("midline.frame_lines", a_frame_lines, 6);
        chk("midline.locked", a_lk, 1);

        // asynchronous reset while locked
        @(negedge clk);
        #2 rst = 1'b1;
        #1 pin_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        frame(6, 10, 0);
        @(negedge clk);
        chk("postreset.locked", a_lk, 0);
        for (int f = 0; f < 5; f++) frame(6, 10, 0);
        @(negedge clk);
        chk("postreset.relock", a_lk, 1);
        chk("postreset.frame_lines", a_frame_lines, 6);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
